// File: rtl/gb_lcd_capture.sv
// -----------------------------------------------------------------------------
// gb_lcd_capture
//   Game Boy LCD bus front-end. The asynchronous GB LCD signals are brought into
//   the clk domain through 2-flop synchronisers. The pixel data is delayed to line
//   up with the deglitched control signals. Pixel events are recovered from the
//   filtered iclk/ihsync edges. Even pixels become framebuffer write requests, which
//   are buffered in a 2-entry valid/ready queue. GB presence is tracked against
//   VGA frame ticks, and this drives the blank flag.
//
// Ports
//   clk        in   1       system clock
//   rst_n      in   1       asynchronous active-low reset
//   idata      in   2       GB LCD pixel data (async)
//   iclk       in   1       GB LCD pixel clock (async)
//   ihsync     in   1       GB LCD hsync (async)
//   ivsync     in   1       GB LCD vsync (async)
//   frame_tick in   1       one-cycle pulse per VGA frame
//   wr_valid   out  1       queue head valid
//   wr_ready   in   1       consumer accepts head when wr_valid & wr_ready
//   wr_addr    out  ADDR_W  framebuffer address of head entry
//   wr_data    out  2       shade of head entry (inverted GB data)
//   blank      out  1       GB input absent
//   overflow   out  1       sticky: a pixel was dropped on a full queue
// -----------------------------------------------------------------------------
module gb_lcd_capture #(
  parameter int FILTER_LEN  = 4,
  parameter int DATA_DELAY  = 5,
  parameter int ADDR_W      = 14,
  parameter int MAX_ADDR    = 11520,
  parameter int MISS_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        idata,
  input  logic              iclk,
  input  logic              ihsync,
  input  logic              ivsync,
  input  logic              frame_tick,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              blank,
  output logic              overflow
);

  // Address limit widened by one bit so that the comparison cannot truncate.
  localparam logic [ADDR_W:0] LP_MAX_ADDR = (ADDR_W+1)'(MAX_ADDR);
  localparam logic [1:0]      LP_MISS     = 2'(MISS_FRAMES);

  // Synchroniser bit layout: {vsync, hsync, clk, data[1:0]}
  logic [4:0]            r_sync1;
  logic [4:0]            r_sync2;
  logic [1:0]            r_data_dly [DATA_DELAY];
  logic [FILTER_LEN-1:0] r_hist_clk;
  logic [FILTER_LEN-1:0] r_hist_hs;
  logic [FILTER_LEN-1:0] r_hist_vs;
  logic                  r_filt_clk;
  logic                  r_filt_hs;
  logic                  r_filt_vs;
  logic [ADDR_W:0]       r_pix;
  logic [1:0]            r_miss;
  logic                  r_blank;
  logic                  r_overflow;

  // Two-slot queue. Slot 0 is always the head.
  logic [1:0]            r_cnt;
  logic                  r_wr_valid;
  logic [ADDR_W-1:0]     r_s0_addr;
  logic [1:0]            r_s0_data;
  logic [ADDR_W-1:0]     r_s1_addr;
  logic [1:0]            r_s1_data;

  logic                  w_clk_nxt;
  logic                  w_hs_nxt;
  logic                  w_vs_nxt;
  logic                  w_clk_fall;
  logic                  w_hs_fall;
  logic                  w_vs_rise;
  logic                  w_pix_evt;
  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_W-1:0]     w_new_addr;
  logic [1:0]            w_new_data;
  logic [1:0]            w_cnt_nxt;
  logic [ADDR_W-1:0]     w_s0_addr_nxt;
  logic [1:0]            w_s0_data_nxt;
  logic [ADDR_W-1:0]     w_s1_addr_nxt;
  logic [1:0]            w_s1_data_nxt;
  logic                  w_ovf_set;

  // A filtered state flips only when the whole history agrees. A mixed history holds it.
  function automatic logic filt_next(input logic [FILTER_LEN-1:0] hist, input logic cur);
    logic res;
    if (hist == {FILTER_LEN{1'b1}}) begin
      res = 1'b1;
    end else if (hist == {FILTER_LEN{1'b0}}) begin
      res = 1'b0;
    end else begin
      res = cur;
    end
    return res;
  endfunction

  // Two-flop synchroniser for all GB LCD inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
    end else begin
      r_sync1 <= {ivsync, ihsync, iclk, idata};
      r_sync2 <= r_sync1;
    end
  end

  // Pixel data history: this delay aligns the data with the filter latency of the control signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DATA_DELAY; i++) begin
        r_data_dly[i] <= 2'd0;
      end
    end else begin
      r_data_dly[0] <= r_sync2[1:0];
      for (int i = 1; i < DATA_DELAY; i++) begin
        r_data_dly[i] <= r_data_dly[i-1];
      end
    end
  end

  // Control-signal sample histories and filtered states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist_clk <= {FILTER_LEN{1'b0}};
      r_hist_hs  <= {FILTER_LEN{1'b0}};
      r_hist_vs  <= {FILTER_LEN{1'b0}};
      r_filt_clk <= 1'b0;
      r_filt_hs  <= 1'b0;
      r_filt_vs  <= 1'b0;
    end else begin
      r_hist_clk <= {r_hist_clk[FILTER_LEN-2:0], r_sync2[2]};
      r_hist_hs  <= {r_hist_hs[FILTER_LEN-2:0],  r_sync2[3]};
      r_hist_vs  <= {r_hist_vs[FILTER_LEN-2:0],  r_sync2[4]};
      r_filt_clk <= w_clk_nxt;
      r_filt_hs  <= w_hs_nxt;
      r_filt_vs  <= w_vs_nxt;
    end
  end

  // Edge recovery and write-request generation
  always_comb begin
    w_clk_nxt  = filt_next(r_hist_clk, r_filt_clk);
    w_hs_nxt   = filt_next(r_hist_hs,  r_filt_hs);
    w_vs_nxt   = filt_next(r_hist_vs,  r_filt_vs);
    w_clk_fall = r_filt_clk & ~w_clk_nxt;
    w_hs_fall  = r_filt_hs  & ~w_hs_nxt;
    w_vs_rise  = ~r_filt_vs & w_vs_nxt;
    // A coincident iclk fall and hsync fall form a single event. A vsync rise discards both.
    w_pix_evt  = ((w_clk_fall & ~r_filt_hs) | w_hs_fall) & ~w_vs_rise;
    // Each framebuffer byte address covers two pixels. Only the even pixel is written.
    w_new_addr = r_pix[ADDR_W:1];
    w_new_data = ~r_data_dly[DATA_DELAY-1];
    w_push     = w_pix_evt & ~r_pix[0] & ({1'b0, w_new_addr} < LP_MAX_ADDR);
    w_pop      = r_wr_valid & wr_ready;
  end

  // Queue next-state logic: hold by default, then decide based on occupancy
  always_comb begin
    w_cnt_nxt     = r_cnt;
    w_s0_addr_nxt = r_s0_addr;
    w_s0_data_nxt = r_s0_data;
    w_s1_addr_nxt = r_s1_addr;
    w_s1_data_nxt = r_s1_data;
    w_ovf_set     = 1'b0;
    case (r_cnt)
      2'd0: begin
        if (w_push) begin
          w_s0_addr_nxt = w_new_addr;
          w_s0_data_nxt = w_new_data;
          w_cnt_nxt     = 2'd1;
        end else begin
          w_cnt_nxt     = 2'd0;
        end
      end
      2'd1: begin
        if (w_push && w_pop) begin
          w_s0_addr_nxt = w_new_addr;
          w_s0_data_nxt = w_new_data;
        end else if (w_pop) begin
          w_cnt_nxt     = 2'd0;
        end else if (w_push) begin
          w_s1_addr_nxt = w_new_addr;
          w_s1_data_nxt = w_new_data;
          w_cnt_nxt     = 2'd2;
        end else begin
          w_cnt_nxt     = 2'd1;
        end
      end
      2'd2: begin
        if (w_push && w_pop) begin
          w_s0_addr_nxt = r_s1_addr;
          w_s0_data_nxt = r_s1_data;
          w_s1_addr_nxt = w_new_addr;
          w_s1_data_nxt = w_new_data;
        end else if (w_pop) begin
          w_s0_addr_nxt = r_s1_addr;
          w_s0_data_nxt = r_s1_data;
          w_cnt_nxt     = 2'd1;
        end else if (w_push) begin
          w_ovf_set     = 1'b1;
        end else begin
          w_cnt_nxt     = 2'd2;
        end
      end
      default: begin
        w_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Queue storage and registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= 2'd0;
      r_wr_valid <= 1'b0;
      r_s0_addr  <= {ADDR_W{1'b0}};
      r_s0_data  <= 2'd0;
      r_s1_addr  <= {ADDR_W{1'b0}};
      r_s1_data  <= 2'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_wr_valid <= (w_cnt_nxt != 2'd0);
      r_s0_addr  <= w_s0_addr_nxt;
      r_s0_data  <= w_s0_data_nxt;
      r_s1_addr  <= w_s1_addr_nxt;
      r_s1_data  <= w_s1_data_nxt;
    end
  end

  // Pixel counter and sticky overflow. Both restart at each frame (vsync rise).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix      <= {(ADDR_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else if (w_vs_rise) begin
      r_pix      <= {(ADDR_W+1){1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_pix_evt) begin
        r_pix <= r_pix + {{ADDR_W{1'b0}}, 1'b1};
      end
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // GB presence: count VGA frames since the last GB vsync. A vsync rise takes priority over a tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_miss  <= 2'd0;
      r_blank <= 1'b1;
    end else if (w_vs_rise) begin
      r_miss  <= 2'd0;
      r_blank <= 1'b0;
    end else if (frame_tick) begin
      if (r_miss >= LP_MISS) begin
        r_blank <= 1'b1;
      end
      if (r_miss != 2'd3) begin
        r_miss <= r_miss + 2'd1;
      end
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_s0_addr;
  assign wr_data  = r_s0_data;
  assign blank    = r_blank;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_gb_lcd_capture.sv
// -----------------------------------------------------------------------------
// tb_gb_lcd_capture
//   Directed bench for gb_lcd_capture. A transaction-level model keeps track of the
//   pixel count, the expected write queue, overflow and presence. The expected
//   value of each write is fixed when the bench drives the edge that causes it.
//   The address limit is scaled down so that the suppression boundary can be
//   reached within a short run.
// -----------------------------------------------------------------------------
module tb_gb_lcd_capture;

  localparam int ADDR_W = 14;
  localparam int TB_MAX = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        idata;
  logic              iclk;
  logic              ihsync;
  logic              ivsync;
  logic              frame_tick;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [1:0]        wr_data;
  logic              blank;
  logic              overflow;

  gb_lcd_capture #(
    .FILTER_LEN(4), .DATA_DELAY(5), .ADDR_W(ADDR_W), .MAX_ADDR(TB_MAX), .MISS_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .idata(idata), .iclk(iclk), .ihsync(ihsync),
    .ivsync(ivsync), .frame_tick(frame_tick), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .blank(blank), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // model state
  int exp_q[$];
  int m_pix;
  bit m_ovf;
  int m_miss;
  bit m_blank;

  // observed writes
  int wr_log[$];
  int n_wr;
  int last_addr;
  int n_chk;
  int n_err;
  bit prev_stall;
  int prev_head;
  int head_exp;
  int base_wr;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // A pixel event has occurred on the GB bus.
  task automatic m_event();
    if ((m_pix % 2) == 0 && (m_pix / 2) < TB_MAX) begin
      if (exp_q.size() < 2) exp_q.push_back((m_pix / 2) * 4 + (3 - int'(idata)));
      else m_ovf = 1'b1;
    end
    m_pix = (m_pix + 1) % 32768;
  endtask

  task automatic vsync_pulse();
    ivsync = 1'b1;
    m_pix = 0; m_ovf = 1'b0; m_miss = 0; m_blank = 1'b0;
    cyc(10);
    ivsync = 1'b0;
    cyc(10);
  endtask

  task automatic hsync_fall();
    ihsync = 1'b1;
    cyc(10);
    ihsync = 1'b0;
    m_event();
    cyc(10);
  endtask

  task automatic iclk_pulse();
    iclk = 1'b1;
    cyc(10);
    iclk = 1'b0;
    m_event();
    cyc(10);
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    if (m_miss >= 2) m_blank = 1'b1;
    if (m_miss < 3) m_miss++;
    cyc(1);
    frame_tick = 1'b0;
  endtask

  // Checks every accepted write against the model and checks that the head stays stable while stalled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        chk("stall_valid", int'(wr_valid), 1);
        chk("stall_head", int'({wr_addr, wr_data}), prev_head);
      end
      if (wr_valid && wr_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_write: got addr %0d data %0d, required no write", wr_addr, wr_data);
        end else begin
          head_exp = exp_q.pop_front();
          chk("wr_entry", int'({wr_addr, wr_data}), head_exp);
        end
        n_wr++;
        last_addr = int'(wr_addr);
        wr_log.push_back(int'({wr_addr, wr_data}));
      end
      prev_stall = wr_valid && !wr_ready;
      prev_head  = int'({wr_addr, wr_data});
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    n_chk = 0; n_err = 0; n_wr = 0; last_addr = -1; prev_stall = 1'b0;
    m_pix = 0; m_ovf = 1'b0; m_miss = 0; m_blank = 1'b1;
    rst_n = 1'b0; idata = 2'b01; iclk = 1'b0; ihsync = 1'b0; ivsync = 1'b0;
    frame_tick = 1'b0; wr_ready = 1'b0;
    cyc(3);
    // reset state
    chk("rst_valid", int'(wr_valid), 0);
    chk("rst_addr", int'(wr_addr), 0);
    chk("rst_data", int'(wr_data), 0);
    chk("rst_blank", int'(blank), 1);
    chk("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    cyc(3);

    // 1: no GB activity, three frame ticks
    for (int i = 0; i < 3; i++) begin
      tick();
      cyc(2);
      chk("idle_blank", int'(blank), int'(m_blank));
    end
    chk("idle_blank_lit", int'(blank), 1);
    chk("idle_valid", int'(wr_valid), 0);

    // 2: one line, one hsync fall + three iclk falls
    wr_ready = 1'b1;
    vsync_pulse();
    chk("vs_blank", int'(blank), 0);
    hsync_fall();
    for (int i = 0; i < 3; i++) iclk_pulse();
    chk("line_nwr", n_wr, 2);
    chk("line_w0", (wr_log.size() > 0) ? wr_log[0] : -1, 2);  // addr 0, data 2'b10
    chk("line_w1", (wr_log.size() > 1) ? wr_log[1] : -1, 6);  // addr 1, data 2'b10
    chk("line_blank", int'(blank), 0);

    // 3: 3-cycle glitch on iclk is not counted
    iclk = 1'b1;
    cyc(3);
    iclk = 1'b0;
    cyc(12);
    chk("glitch_nwr", n_wr, 2);
    idata = 2'b11;
    iclk_pulse();                       // pix 4 -> addr 2, data 2'b00
    chk("glitch_nwr2", n_wr, 3);
    chk("glitch_addr", last_addr, 2);
    chk("glitch_data", (wr_log.size() > 2) ? wr_log[2] : -1, 8);
    idata = 2'b01;

    // 4: stalled consumer, four even pixels
    vsync_pulse();
    wr_ready = 1'b0;
    base_wr = n_wr;
    hsync_fall();
    for (int i = 0; i < 6; i++) iclk_pulse();
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_model", int'(overflow), int'(m_ovf));
    chk("ovf_valid", int'(wr_valid), 1);
    chk("ovf_head", int'({wr_addr, wr_data}), 2);
    wr_ready = 1'b1;
    cyc(6);
    chk("ovf_drained", n_wr - base_wr, 2);
    chk("ovf_last", last_addr, 1);
    chk("ovf_qempty", exp_q.size(), 0);
    chk("ovf_sticky", int'(overflow), 1);

    // 5: presence timeout
    vsync_pulse();
    chk("ovf_cleared", int'(overflow), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("miss_blank", int'(blank), int'(m_blank));
      chk("miss_blank_lit", int'(blank), 0);
      cyc(2);
    end
    tick();
    chk("miss3_blank", int'(blank), 1);
    chk("miss3_model", int'(blank), int'(m_blank));

    // 6: address limit
    vsync_pulse();
    base_wr = n_wr;
    hsync_fall();
    for (int i = 0; i < 2 * TB_MAX + 3; i++) iclk_pulse();
    chk("lim_count", n_wr - base_wr, TB_MAX);
    chk("lim_last", last_addr, TB_MAX - 1);
    chk("lim_qempty", exp_q.size(), 0);

    // 7: reset mid-operation flushes a pending entry
    wr_ready = 1'b0;
    vsync_pulse();
    hsync_fall();
    chk("pre_rst_valid", int'(wr_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(wr_valid), 0);
    chk("mid_rst_blank", int'(blank), 1);
    chk("mid_rst_addr", int'(wr_addr), 0);
    exp_q.delete();
    m_pix = 0; m_ovf = 1'b0; m_miss = 0; m_blank = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    cyc(5);
    chk("post_rst_valid", int'(wr_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
